// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC vectoring encoder and its step stage.
package cordic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    // Bit positions of one step's code {c2,c1,c0}
    localparam int unsigned C0 = 0;
    localparam int unsigned C1 = 1;
    localparam int unsigned C2 = 2;

    localparam int unsigned KBASE_DEFAULT = 5;

endpackage

// File: rtl/cordic_vec_step.sv
// One enhanced CORDIC vectoring micro-rotation: picks shift/direction/skip from X,Y
// and produces the rotated vector plus the 3-bit control code.
module cordic_vec_step
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned KBASE = KBASE_DEFAULT
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] x_next,
    output logic [WIDTH-1:0] y_next,
    output logic [2:0]       code
);

    logic signed [WIDTH-1:0] xs, ys;
    logic signed [WIDTH-1:0] t1_w, t2_w;
    logic signed [WIDTH:0]   y_ext, y_mag;
    logic signed [WIDTH+1:0] mag, t1, t2;
    logic signed [WIDTH-1:0] xs_k, ys_k, xs_2k, ys_2k;
    int unsigned             sh, sh2;

    assign xs = $signed(x);
    assign ys = $signed(y);

    always_comb begin
        t1_w  = xs >>> (KBASE + 1);
        t2_w  = xs >>> (KBASE + 2);
        // Extra magnitude bit keeps |-2^(WIDTH-1)| representable
        y_ext = {ys[WIDTH-1], ys};
        y_mag = y_ext[WIDTH] ? -y_ext : y_ext;
        mag   = {1'b0, y_mag};
        t1    = {{2{t1_w[WIDTH-1]}}, t1_w};
        t2    = {{2{t2_w[WIDTH-1]}}, t2_w};

        code = 3'b000;
        if (mag >= t1) begin
            code[C0] = 1'b1;
        end else if (mag >= t2) begin
            code[C0] = 1'b1;
            code[C1] = 1'b1;
        end
        code[C2] = code[C0] & ~ys[WIDTH-1] & (ys != '0);

        sh    = KBASE + {31'd0, code[C1]};
        sh2   = 2 * sh + 1;
        xs_k  = xs >>> sh;
        ys_k  = ys >>> sh;
        xs_2k = xs >>> sh2;
        ys_2k = ys >>> sh2;

        x_next = x;
        y_next = y;
        if (code[C0]) begin
            if (code[C2]) begin
                x_next = xs - xs_2k + ys_k;
                y_next = ys - ys_2k - xs_k;
            end else begin
                x_next = xs - xs_2k - ys_k;
                y_next = ys - ys_2k + xs_k;
            end
        end
    end

endmodule

// File: rtl/cordic_vec_encoder.sv
// Iterative CORDIC vectoring engine: runs NITER micro-rotations per accepted vector
// and reports the final vector with the per-step control codes for a replaying rotator.
module cordic_vec_encoder
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NITER = 4,
    parameter int unsigned KBASE = KBASE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [WIDTH-1:0]     y_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     x_out,
    output logic [WIDTH-1:0]     y_out,
    output logic [3*NITER-1:0]   code_out
);

    localparam int unsigned SW = (NITER > 1) ? $clog2(NITER) : 1;

    state_t             state_q;
    logic [SW-1:0]      step_q;
    logic [WIDTH-1:0]   x_q, y_q;
    logic [3*NITER-1:0] code_q;
    logic               in_ready_q, out_valid_q;

    logic [WIDTH-1:0]   x_nx, y_nx;
    logic [2:0]         step_code;

    cordic_vec_step #(
        .WIDTH (WIDTH),
        .KBASE (KBASE)
    ) u_step (
        .x      (x_q),
        .y      (y_q),
        .x_next (x_nx),
        .y_next (y_nx),
        .code   (step_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            code_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q        <= x_in;
                        y_q        <= y_in;
                        code_q     <= '0;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    x_q                  <= x_nx;
                    y_q                  <= y_nx;
                    code_q[3*step_q +: 3] <= step_code;
                    if (step_q == SW'(NITER - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        step_q <= step_q + SW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign code_out  = code_q;

endmodule

// File: doc/cordic_vec_encoder.md
# cordic_vec_encoder

Iterative CORDIC vectoring engine that drives a signed (X, Y) vector toward the X axis with enhanced micro-rotations. It emits, per step, the 3-bit control code {c2,c1,c0} that the rotation-stage chain consumes, so a downstream rotator replays the same trajectory. It sits on the analysis side of the datapath and is the encoder for the rotation-stage decoder chain. Each step uses shift k = KBASE + c1, a second-order scale correction and a skip option.

## Interface
- WIDTH, 16: X/Y datapath width, two's complement.
- NITER, 4: micro-rotation steps per vector (≥1).
- KBASE, 5: base shift; step shift k is KBASE or KBASE+1.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept (high only in IDLE).
- x_in  in  WIDTH  signed X, expected ≥ 0.
- y_in  in  WIDTH  signed Y.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- x_out  out  WIDTH  final X.
- y_out  out  WIDTH  final residual Y.
- code_out  out  3*NITER  step i code at [3i+2:3i] = {c2,c1,c0}.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; x/y registers, code register and step counter cleared. Reset values: in_ready=1, out_valid=0, x_out=0, y_out=0, code_out=0.
- IDLE: in_ready=1. On in_valid&in_ready, load X←x_in, Y←y_in, codes←0, step←0, go RUN.
- RUN: one step per cycle, decided combinationally from current X,Y. T1 = X>>>(KBASE+1), T2 = X>>>(KBASE+2), |Y| as unsigned magnitude (WIDTH+1 bits, so −2^(WIDTH−1) is handled).
  - |Y| ≥ T1 → c0=1, c1=0.
  - Otherwise |Y| ≥ T2 → c0=1, c1=1.
  - Otherwise c0=0, c1=0, c2=0; X,Y unchanged.
  - When c0=1: c2=1 if Y>0, else 0. s = 2·c2−1.
- Update, both from the old X,Y, all shifts arithmetic, results truncated to WIDTH (wrap, no saturation):
  - X' = X − (X>>>(2k+1)) + s·(Y>>>k)
  - Y' = Y − (Y>>>(2k+1)) − s·(X>>>k)
- The step's code is written to slot [3·step+2:3·step]. When step = NITER−1, go to DONE; otherwise step+1.
- DONE: out_valid=1. x_out, y_out and code_out are held stable until out_valid&out_ready, then go to IDLE. in_ready=0.
- in_valid in RUN/DONE is ignored; there is no queuing.
- Reset mid-RUN/DONE aborts immediately. The partial result is never presented.

## Timing
- Accept at edge E0. Step i completes at edge E0+1+i. out_valid rises after edge E0+NITER, i.e. NITER cycles after acceptance.
- out_ready already high at the first out_valid cycle → one-cycle result; IDLE the next cycle.
- Minimum spacing between accepts is NITER+2 cycles.
- x_out, y_out and code_out are registered, with no combinational path from inputs to outputs.
- in_ready and out_valid are decoded from registered state only.

## Structure
- Shared package (cordic_pkg): state enum, code bit positions (C2/C1/C0 indices), KBASE default.
- One sub-module, cordic_vec_step: combinational decision plus update for one step (X,Y → X',Y', code). It is reusable for an unrolled variant.
- Top holds the FSM, step counter, X/Y registers and code shift/slot register.

## Test plan
- Reset, then x_in=16384, y_in=0 → code_out=12'h000, x_out=16384, y_out=0, out_valid 4 cycles after accept.
- x_in=16384, y_in=1024:
  - Step 0: k=5, code 101, X=16408, Y=512.
  - Step 1: code 101, X=16416, Y=0.
  - Result: code_out=12'h02D, x_out=16416, y_out=0.
- x_in=16384, y_in=−200:
  - Step 0: k=6, c2=0, code 011, X=16386, Y=57.
  - Then skip steps.
  - Result: code_out=12'h003, x_out=16386, y_out=57.
- Backpressure: out_ready low 5 cycles in DONE → out_valid stays 1, outputs unchanged, in_ready=0, in_valid pulses ignored. Then out_ready=1 → IDLE next cycle.
- Assert rst during RUN step 2 → out_valid=0, in_ready=1 at once. No result appears; the next vector processes normally.
- Back-to-back vectors with out_ready tied high → accepts spaced exactly NITER+2 cycles, each result matches a golden model of the update equations.
